// File: rtl/dart_pkg.sv
// dart_pkg -- shared definitions for the dart scorer.
// Holds the game state encoding and the score / points widths used by
// dart_scorer and dart_score_reg. No ports.
package dart_pkg;

  localparam int SCORE_W  = 6;
  localparam int POINTS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2
  } state_t;

endpackage

// File: rtl/dart_score_reg.sv
// dart_score_reg -- one player's remaining score plus its turn snapshot.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (score = snapshot = TARGET)
//   load     in   new game: score = snapshot = TARGET
//   restore  in   bust: score returns to the turn snapshot
//   update   in   accepted throw: score = value
//   snap     in   turn begins for this player: snapshot = current score
//   value    in   new score for update
//   score    out  remaining score (registered)
// Controls are prioritised load > restore > update; snap is independent
// because the top only snapshots the player that is not throwing.
module dart_score_reg
  import dart_pkg::*;
#(
  parameter int TARGET = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               restore,
  input  logic               update,
  input  logic               snap,
  input  logic [SCORE_W-1:0] value,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] TARGET_V = SCORE_W'(TARGET);

  logic [SCORE_W-1:0] snapshot;

  // Score and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      score    <= TARGET_V;
      snapshot <= TARGET_V;
    end else if (load) begin
      score    <= TARGET_V;
      snapshot <= TARGET_V;
    end else begin
      if (restore) begin
        score <= snapshot;
      end else if (update) begin
        score <= value;
      end else begin
        score <= score;
      end
      if (snap) begin
        snapshot <= score;
      end else begin
        snapshot <= snapshot;
      end
    end
  end

endmodule

// File: rtl/dart_scorer.sv
// dart_scorer -- two-player countdown dart scoring engine.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   pulse: begin / restart a game
//   throw_valid  in   P carries one throw this cycle
//   P[1:0]       in   points of the throw (0..3)
//   ready        out  throws accepted (PLAY state)
//   player       out  current player
//   throw_cnt    out  throws already taken this turn
//   score0/1     out  remaining score per player
//   bust         out  one-cycle pulse on a bust
//   win          out  game over (level)
//   winner       out  winning player, valid while win=1
// Optional feature: define DART_DOUBLE_OUT_EN so that reaching exactly zero
// only wins with a 3-point throw; any other exact finish busts.
module dart_scorer
  import dart_pkg::*;
#(
  parameter int TARGET          = 31,
  parameter int THROWS_PER_TURN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                throw_valid,
  input  logic [POINTS_W-1:0] P,
  output logic                ready,
  output logic                player,
  output logic [1:0]          throw_cnt,
  output logic [SCORE_W-1:0]  score0,
  output logic [SCORE_W-1:0]  score1,
  output logic                bust,
  output logic                win,
  output logic                winner
);

  localparam logic [1:0] LAST_THROW = 2'(THROWS_PER_TURN - 1);

  state_t state;

  logic               accept;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   rem;
  logic               borrow;
  logic               zero;
  logic               win_throw;
  logic               bust_throw;
  logic               normal_throw;
  logic               turn_end;
  logic               load;
  logic               restore0, restore1;
  logic               update0, update1;
  logic               snap0, snap1;

  // Throw evaluation and per-player score controls.
  always_comb begin
    accept       = (state == PLAY) && throw_valid && !start;
    cur_score    = player ? score1 : score0;
    rem          = {1'b0, cur_score} - {{(SCORE_W - POINTS_W + 1){1'b0}}, P};
    borrow       = rem[SCORE_W];
    zero         = (rem == 7'd0);
`ifdef DART_DOUBLE_OUT_EN
    win_throw    = zero && (P == 2'd3);
`else
    win_throw    = zero;
`endif
    bust_throw   = borrow || (zero && !win_throw);
    normal_throw = !borrow && !zero;
    // The turn passes to the other player on a bust or after the last throw.
    turn_end     = accept && (bust_throw || (normal_throw && (throw_cnt == LAST_THROW)));
    load         = start;
    update0      = accept && !player && (normal_throw || win_throw);
    update1      = accept &&  player && (normal_throw || win_throw);
    restore0     = accept && !player && bust_throw;
    restore1     = accept &&  player && bust_throw;
    // Snapshot the incoming player's score when the turn changes hands.
    snap0        = turn_end &&  player;
    snap1        = turn_end && !player;
  end

  dart_score_reg #(.TARGET(TARGET)) u_score0 (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .restore (restore0),
    .update  (update0),
    .snap    (snap0),
    .value   (rem[SCORE_W-1:0]),
    .score   (score0)
  );

  dart_score_reg #(.TARGET(TARGET)) u_score1 (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .restore (restore1),
    .update  (update1),
    .snap    (snap1),
    .value   (rem[SCORE_W-1:0]),
    .score   (score1)
  );

  // Game FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      player    <= 1'b0;
      throw_cnt <= 2'd0;
      bust      <= 1'b0;
      win       <= 1'b0;
      winner    <= 1'b0;
    end else begin
      bust <= 1'b0;
      case (state)
        IDLE, WIN: begin
          if (start) begin
            state     <= PLAY;
            ready     <= 1'b1;
            player    <= 1'b0;
            throw_cnt <= 2'd0;
            win       <= 1'b0;
          end else begin
            state <= state;
          end
        end
        PLAY: begin
          if (start) begin
            state     <= PLAY;
            ready     <= 1'b1;
            player    <= 1'b0;
            throw_cnt <= 2'd0;
            win       <= 1'b0;
          end else if (throw_valid) begin
            if (win_throw) begin
              state  <= WIN;
              ready  <= 1'b0;
              win    <= 1'b1;
              winner <= player;
            end else if (bust_throw) begin
              bust      <= 1'b1;
              player    <= ~player;
              throw_cnt <= 2'd0;
            end else if (throw_cnt == LAST_THROW) begin
              player    <= ~player;
              throw_cnt <= 2'd0;
            end else begin
              throw_cnt <= throw_cnt + 2'd1;
            end
          end else begin
            state <= PLAY;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dart_scorer.md
DART_SCORER -- requirements
Module: dart_scorer

Interface
REQ-001 SHALL have parameter TARGET, default 31, meaning the starting score per player (1..63).
REQ-002 SHALL have parameter THROWS_PER_TURN, default 3, meaning the throws per player turn (1..3).
REQ-003 SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins or restarts a game.
REQ-007 throw_valid  input  1  P carries one throw result this cycle.
REQ-008 P  input  2  points of one throw (0..3), driven by the upstream dart point decoder.
REQ-009 ready  output  1  scorer accepts throws.
REQ-010 player  output  1  current player (0 or 1).
REQ-011 throw_cnt  output  2  throws already taken in the current turn.
REQ-012 score0, score1  output  6 each  remaining score per player.
REQ-013 bust  output  1  one-cycle pulse on a bust.
REQ-014 win  output  1  game over, level signal.
REQ-015 winner  output  1  winning player, valid while win=1.

Function
REQ-016 SHALL implement states IDLE, PLAY and WIN; ready=1 only in PLAY.
REQ-017 IDLE->PLAY on start; PLAY->WIN on a finishing throw; WIN->PLAY on start; all other inputs hold the state.
REQ-018 On start: score0=score1=TARGET, player=0, throw_cnt=0, win=0, turn snapshot=TARGET.
REQ-019 A throw is accepted only when ready=1 and throw_valid=1; a throw_valid in IDLE or WIN is ignored.
REQ-020 Outputs reflect an accepted throw after the next rising edge (1-cycle latency); one throw per cycle, back-to-back allowed.
REQ-021 Compute rem = score[player] - P, unsigned, 7-bit with borrow.
REQ-022 If rem>0: score[player]=rem and throw_cnt increments.
REQ-023 If that throw is the turn's last (throw_cnt==THROWS_PER_TURN-1): toggle player, clear throw_cnt and snapshot the new player's score.
REQ-024 If P>score[player] (borrow): bust=1 for one cycle, score[player] restored to the turn snapshot, player toggles, throw_cnt=0.
REQ-025 If rem==0 (subject to REQ-032): score[player]=0, win=1, winner=player, go to WIN, and freeze the scores.
REQ-026 P=0 SHALL count as a throw (miss).
REQ-027 If start and throw_valid occur in the same cycle, start wins and the throw is discarded.
REQ-028 A start in PLAY restarts the game per REQ-018.

Reset
REQ-029 rst SHALL have priority over all inputs.
REQ-030 Reset values: state=IDLE, ready=0, player=0, throw_cnt=0, score0=score1=TARGET, bust=0, win=0, winner=0.
REQ-031 A reset mid-turn or in WIN SHALL discard all progress; no throw is accepted in the reset cycle.

Configuration
REQ-032 With macro DART_DOUBLE_OUT_EN defined, rem==0 wins only if P==3; rem==0 with P!=3 is treated as a bust (REQ-024).
REQ-033 Without DART_DOUBLE_OUT_EN, any throw reaching exactly 0 wins.

Structure
REQ-034 Package dart_pkg SHALL hold the state encoding (IDLE=0, PLAY=1, WIN=2), the score width constant (6) and the points width constant (2).
REQ-035 Sub-module dart_score_reg SHALL hold one player's score plus turn snapshot, with load, update and restore controls; it is instantiated twice.

Verification (TARGET=5, THROWS_PER_TURN=3)
REQ-036 Reset, then throw_valid with P=3 and no start -> ready=0, scores stay 5/5, no state change.
REQ-037 start, then P0 throws 1,1,1 -> score0=2, player=1, throw_cnt=0, bust never asserted.
REQ-038 From score0=2 (snapshot 2), P0 throws P=3 -> bust=1 for one cycle, score0=2, player=1.
REQ-039 From score0=2, P0 throws 2 -> without the macro: win=1, winner=0, ready=0; with DART_DOUBLE_OUT_EN: bust=1, score0=2.
REQ-040 start and throw_valid (P=3) in the same cycle during PLAY -> scores=5/5, player=0, throw ignored.
REQ-041 rst asserted mid-turn (throw_cnt=2) -> next cycle all reset values per REQ-030.
